// File: rtl/fifo_pkg.sv
// Shared constants and types for the parametrised FIFO.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_AE_THRESH  = 2;
    localparam int unsigned DEF_FWFT       = 0;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    // Map the integer FWFT parameter onto the read-mode enum.
    function automatic fifo_mode_e mode_of(input int unsigned fwft);
        return (fwft != 0) ? FWFT : STD;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake / status bundle between a FIFO user (master) and the FIFO (slave).
interface param_fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  clr_i;
    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  rd_en_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic [ADDR_WIDTH:0]   level_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output clr_i, wr_en_i, data_i, rd_en_i,
        input  data_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
               level_o, overflow_o, underflow_o
    );

    modport slave (
        input  clr_i, wr_en_i, data_i, rd_en_i,
        output data_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
               level_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

    // Storage array write port (no reset on the array itself).
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register holds its value unless a read is issued.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem_q[raddr_i];
    end

    // Read data register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/param_fifo.sv
// Parametrised synchronous FIFO with standard or first-word-fall-through read.
module param_fifo #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH,
    parameter int unsigned AF_THRESH  = (2**ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = fifo_pkg::DEF_AE_THRESH,
    parameter int unsigned FWFT       = fifo_pkg::DEF_FWFT
) (
    input  logic         clk,
    input  logic         rst,
    param_fifo_if.slave  bus
);
    import fifo_pkg::*;

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned LW    = ADDR_WIDTH + 1;
    localparam fifo_mode_e  MODE  = mode_of(FWFT);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  full, empty, wr_acc, rd_acc, mem_re;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign full   = (level_q == LW'(DEPTH));
    assign wr_acc = bus.wr_en_i & ~full  & ~bus.clr_i;
    assign rd_acc = bus.rd_en_i & ~empty & ~bus.clr_i;

    // Pointer, level and sticky-flag bookkeeping; flush overrides everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (bus.wr_en_i & full);
        unf_d    = unf_q | (bus.rd_en_i & empty);
        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (mem_re) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        if (wr_acc && !rd_acc)      level_d = level_q + LW'(1);
        else if (rd_acc && !wr_acc) level_d = level_q - LW'(1);
        if (bus.clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
    end

    // Bookkeeping state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_i),
        .re_i    (mem_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    if (MODE == fifo_pkg::FWFT) begin : g_fwft
        // Two-stage prefetch: RAM read register (mid) feeds the output register.
        // level counts words in RAM plus mid plus output, so ram_cnt is derived.
        logic                  out_valid_q, out_valid_d, mid_valid_q, mid_valid_d;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
        logic [LW-1:0]         ram_cnt;
        logic                  out_load;

        assign ram_cnt  = level_q - LW'(out_valid_q) - LW'(mid_valid_q);
        assign empty    = ~out_valid_q;
        assign out_load = mid_valid_q & (~out_valid_q | rd_acc);
        assign mem_re   = (ram_cnt != '0) & (~mid_valid_q | out_load) & ~bus.clr_i;

        // Advance the prefetch pipeline on pop or when the output slot is free.
        always_comb begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            mid_valid_d = mid_valid_q;
            if (out_load) begin
                out_valid_d = 1'b1;
                out_data_d  = mem_rdata;
            end else if (rd_acc) begin
                out_valid_d = 1'b0;
            end
            if (mem_re)        mid_valid_d = 1'b1;
            else if (out_load) mid_valid_d = 1'b0;
            if (bus.clr_i) begin
                out_valid_d = 1'b0;
                mid_valid_d = 1'b0;
            end
        end

        // Prefetch pipeline state register.
        always_ff @(posedge clk) begin
            if (!rst) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
                mid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
                mid_valid_q <= mid_valid_d;
            end
        end

        assign bus.data_o  = out_data_q;
        assign bus.valid_o = out_valid_q;
    end else begin : g_std
        logic valid_q, valid_d;

        assign empty  = (level_q == '0);
        assign mem_re = rd_acc;

        // Read data is valid for exactly the cycle after an accepted read.
        always_comb begin
            valid_d = rd_acc;
        end

        // Valid flag register.
        always_ff @(posedge clk) begin
            if (!rst) valid_q <= 1'b0;
            else      valid_q <= valid_d;
        end

        assign bus.data_o  = mem_rdata;
        assign bus.valid_o = valid_q;
    end

    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.almost_full_o  = (level_q >= LW'(AF_THRESH));
    assign bus.almost_empty_o = (level_q <= LW'(AE_THRESH));
    assign bus.level_o        = level_q;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = unf_q;
endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench: one standard-mode and one FWFT-mode FIFO.
module tb_param_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    param_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) sif ();
    param_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) fif ();

    param_fifo #(
        .DATA_WIDTH (32), .ADDR_WIDTH (4), .AF_THRESH (14), .AE_THRESH (2), .FWFT (0)
    ) dut_std (.clk(clk), .rst(rst), .bus(sif));

    param_fifo #(
        .DATA_WIDTH (32), .ADDR_WIDTH (4), .AF_THRESH (14), .AE_THRESH (2), .FWFT (1)
    ) dut_fwft (.clk(clk), .rst(rst), .bus(fif));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic s_write(input logic [31:0] d);
        sif.wr_en_i = 1'b1;
        sif.data_i  = d;
        tick();
        sif.wr_en_i = 1'b0;
    endtask

    task automatic s_read_check(input string tag, input logic [31:0] exp);
        sif.rd_en_i = 1'b1;
        tick();
        sif.rd_en_i = 1'b0;
        check({tag, "_data"}, sif.data_o, exp);
        check({tag, "_valid"}, sif.valid_o, 1'b1);
    endtask

    task automatic f_pop;
        fif.rd_en_i = 1'b1;
        tick();
        fif.rd_en_i = 1'b0;
    endtask

    task automatic check_reset_std(input string tag);
        check({tag, "_level"}, sif.level_o, 0);
        check({tag, "_empty"}, sif.empty_o, 1);
        check({tag, "_ae"},    sif.almost_empty_o, 1);
        check({tag, "_full"},  sif.full_o, 0);
        check({tag, "_af"},    sif.almost_full_o, 0);
        check({tag, "_valid"}, sif.valid_o, 0);
        check({tag, "_data"},  sif.data_o, 0);
        check({tag, "_ovf"},   sif.overflow_o, 0);
        check({tag, "_unf"},   sif.underflow_o, 0);
    endtask

    // Fill to 16, overflow once, then read 7 back: level 9 with overflow set.
    task automatic s_level9_ovf;
        for (int i = 0; i < 16; i++) s_write(32'h400 + i);
        s_write(32'h4FF);
        for (int i = 0; i < 7; i++) s_read_check("l9_rd", 32'h400 + i);
        check("l9_level", sif.level_o, 9);
        check("l9_ovf", sif.overflow_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sif.clr_i = 0; sif.wr_en_i = 0; sif.rd_en_i = 0; sif.data_i = '0;
        fif.clr_i = 0; fif.wr_en_i = 0; fif.rd_en_i = 0; fif.data_i = '0;
        tick();
        tick();
        check_reset_std("rst");
        check("rst_fwft_valid", fif.valid_o, 0);
        check("rst_fwft_empty", fif.empty_o, 1);
        rst = 1'b1;
        tick();

        // Fill
        for (int i = 0; i < 16; i++) begin
            s_write(32'h100 + i);
            check("fill_level", sif.level_o, i + 1);
            check("fill_af", sif.almost_full_o, (i + 1) >= 14);
        end
        check("fill_full", sif.full_o, 1);
        s_write(32'h1FF);
        check("ovf_set", sif.overflow_o, 1);
        check("ovf_level", sif.level_o, 16);

        // Drain in standard mode
        for (int i = 0; i < 16; i++) begin
            s_read_check("drain", 32'h100 + i);
            check("drain_ae", sif.almost_empty_o, (15 - i) <= 2);
        end
        tick();
        check("drain_valid_low", sif.valid_o, 0);
        check("drain_data_hold", sif.data_o, 32'h10F);
        check("drain_empty", sif.empty_o, 1);
        sif.rd_en_i = 1'b1;
        tick();
        sif.rd_en_i = 1'b0;
        check("unf_set", sif.underflow_o, 1);
        check("unf_valid", sif.valid_o, 0);
        check("unf_level", sif.level_o, 0);
        check("ovf_sticky", sif.overflow_o, 1);
        sif.clr_i = 1'b1;
        tick();
        sif.clr_i = 1'b0;
        check("clr_ovf", sif.overflow_o, 0);
        check("clr_unf", sif.underflow_o, 0);

        // Pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) s_write(32'h200 + r * 16 + i);
            for (int i = 0; i < 10; i++) s_read_check("wrap", 32'h200 + r * 16 + i);
            check("wrap_level", sif.level_o, 0);
        end

        // Simultaneous read/write at level 8
        for (int i = 0; i < 8; i++) s_write(32'h300 + i);
        check("sim_start_level", sif.level_o, 8);
        for (int k = 0; k < 20; k++) begin
            sif.wr_en_i = 1'b1;
            sif.rd_en_i = 1'b1;
            sif.data_i  = 32'h308 + k;
            tick();
            check("sim_data", sif.data_o, 32'h300 + k);
            check("sim_level", sif.level_o, 8);
        end
        sif.wr_en_i = 1'b0;
        sif.rd_en_i = 1'b0;
        for (int i = 0; i < 8; i++) s_read_check("sim_tail", 32'h314 + i);
        check("sim_end_level", sif.level_o, 0);

        // Flush with a same-cycle write
        s_level9_ovf();
        sif.clr_i   = 1'b1;
        sif.wr_en_i = 1'b1;
        sif.data_i  = 32'h777;
        tick();
        sif.clr_i   = 1'b0;
        sif.wr_en_i = 1'b0;
        check("flush_level", sif.level_o, 0);
        check("flush_ovf", sif.overflow_o, 0);
        check("flush_empty", sif.empty_o, 1);
        check("flush_valid", sif.valid_o, 0);

        // Reset mid-operation with a same-cycle write
        s_level9_ovf();
        rst = 1'b0;
        sif.wr_en_i = 1'b1;
        sif.data_i  = 32'h888;
        tick();
        rst = 1'b1;
        sif.wr_en_i = 1'b0;
        check_reset_std("midrst");
        s_write(32'h55);
        check("post_rst_level", sif.level_o, 1);
        s_read_check("post_rst", 32'h55);

        // FWFT: fall-through latency
        fif.wr_en_i = 1'b1;
        fif.data_i  = 32'hA5;
        tick();
        fif.wr_en_i = 1'b0;
        check("fw_wr_level", fif.level_o, 1);
        check("fw_wr_valid0", fif.valid_o, 0);
        tick();
        check("fw_wr_valid1", fif.valid_o, 0);
        tick();
        check("fw_ft_valid", fif.valid_o, 1);
        check("fw_ft_data", fif.data_o, 32'hA5);
        check("fw_ft_empty", fif.empty_o, 0);

        // FWFT: pop presents the next word
        fif.wr_en_i = 1'b1;
        fif.data_i  = 32'hB6;
        tick();
        fif.wr_en_i = 1'b0;
        check("fw_b6_level", fif.level_o, 2);
        tick();
        f_pop();
        check("fw_pop_data", fif.data_o, 32'hB6);
        check("fw_pop_valid", fif.valid_o, 1);
        check("fw_pop_level", fif.level_o, 1);

        // FWFT: simultaneous write and pop at level 1
        fif.wr_en_i = 1'b1;
        fif.rd_en_i = 1'b1;
        fif.data_i  = 32'hC7;
        tick();
        fif.wr_en_i = 1'b0;
        fif.rd_en_i = 1'b0;
        check("fw_wp_level", fif.level_o, 1);
        tick();
        tick();
        check("fw_wp_data", fif.data_o, 32'hC7);
        check("fw_wp_valid", fif.valid_o, 1);
        f_pop();
        check("fw_last_valid", fif.valid_o, 0);
        check("fw_last_empty", fif.empty_o, 1);
        check("fw_last_level", fif.level_o, 0);

        // FWFT: back-to-back pops without bubbles
        for (int i = 0; i < 4; i++) begin
            fif.wr_en_i = 1'b1;
            fif.data_i  = 32'hD0 + i;
            tick();
        end
        fif.wr_en_i = 1'b0;
        tick();
        tick();
        check("fw_str_level", fif.level_o, 4);
        check("fw_str_head", fif.data_o, 32'hD0);
        for (int i = 0; i < 3; i++) begin
            f_pop();
            check("fw_str_data", fif.data_o, 32'hD1 + i);
            check("fw_str_valid", fif.valid_o, 1);
        end
        f_pop();
        check("fw_str_end_valid", fif.valid_o, 0);
        check("fw_str_end_ae", fif.almost_empty_o, 1);
        f_pop();
        check("fw_unf", fif.underflow_o, 1);
        check("fw_unf_level", fif.level_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, with DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2; almost_full_o asserts when level_o >= AF_THRESH.
REQ-004 SHALL have parameter AE_THRESH, default 2; almost_empty_o asserts when level_o <= AE_THRESH.
REQ-005 SHALL have parameter FWFT, default 0; 0 selects standard read mode, 1 selects first-word-fall-through mode.
REQ-006 SHALL have ports, one per line:
  clk  input  1  single clock, rising edge.
  rst  input  1  synchronous active-low reset.
  clr_i  input  1  synchronous flush, active-high.
  wr_en_i  input  1  write request.
  data_i  input  DATA_WIDTH  write data.
  rd_en_i  input  1  read request (pop in FWFT mode).
  data_o  output  DATA_WIDTH  read data.
  valid_o  output  1  data_o holds a valid word.
  full_o  output  1  level_o == DEPTH.
  empty_o  output  1  no readable word.
  almost_full_o  output  1  threshold flag.
  almost_empty_o  output  1  threshold flag.
  level_o  output  ADDR_WIDTH+1  stored word count, 0..DEPTH.
  overflow_o  output  1  sticky: write attempted while full.
  underflow_o  output  1  sticky: read attempted while empty.

Function
REQ-007 SHALL accept a write when wr_en_i=1 and full_o=0, and SHALL ignore a write when full_o=0 is false.
REQ-008 SHALL accept a read when rd_en_i=1 and empty_o=0, and SHALL ignore a read otherwise.
REQ-009 SHALL hold all DEPTH entries, with no entry reserved.
REQ-010 SHALL update level_o on the next edge as +1 for a write only, -1 for a read only, and unchanged for simultaneous accepted read and write.
REQ-011 SHALL wrap the write and read pointers modulo DEPTH, with full/empty distinguished by level_o, not by pointer equality.
REQ-012 In standard mode (FWFT=0), SHALL present the read word on data_o with valid_o=1 exactly one cycle after an accepted read, and SHALL hold data_o with valid_o=0 otherwise.
REQ-013 In standard mode, empty_o SHALL equal (level_o==0).
REQ-014 In FWFT mode, SHALL present the head word on data_o with valid_o=1 without a read request, and an accepted read SHALL pop the head.
REQ-015 In FWFT mode, a write into an empty FIFO SHALL produce valid_o=1 two cycles after the write edge.
REQ-016 In FWFT mode, a pop SHALL present the next stored word in the following cycle, with no bubble while level_o > 1.
REQ-017 In FWFT mode, empty_o SHALL equal !valid_o, and level_o SHALL include the word held in the output register.
REQ-018 In FWFT mode, simultaneous write and pop at level 1 SHALL yield the new word on data_o and level 1.
REQ-019 SHALL set overflow_o on wr_en_i=1 while full_o=1, and SHALL set underflow_o on rd_en_i=1 while empty_o=1; both SHALL stay set until clr_i or reset.
REQ-020 clr_i=1 SHALL zero the pointers and level_o, deassert valid_o and the sticky flags, and override a same-cycle wr_en_i or rd_en_i.
REQ-021 SHALL derive full_o, empty_o, almost_full_o and almost_empty_o from registered state only, with no combinational path from any input.

Reset
REQ-022 On rst=0 at a clock edge, SHALL drive level_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, valid_o=0, data_o=0, overflow_o=0 and underflow_o=0.
REQ-023 Reset mid-operation SHALL discard all stored words, with the first write after release accepted normally.

Structure
REQ-024 SHALL place the default parameter constants and a fifo_mode_e typedef (STD, FWFT) in a shared package fifo_pkg.
REQ-025 SHALL instantiate one sub-module, fifo_mem: a simple dual-port RAM with registered read, one write port and one read port, parametrised by DATA_WIDTH and ADDR_WIDTH.

Verification
(Bench: DATA_WIDTH=32, ADDR_WIDTH=4, DEPTH=16, AF_THRESH=14, AE_THRESH=2.)
REQ-026 Fill: write 16 words 0x100..0x10F -> full_o=1 after the 16th, almost_full_o=1 from level 14; a 17th write sets overflow_o, and level_o stays 16.
REQ-027 Drain in standard mode: 16 reads -> data_o returns 0x100..0x10F in order, one cycle after each read; an extra read sets underflow_o, and empty_o=1.
REQ-028 Wrap: repeat 3 times "write 10, read 10" -> data stays in order across the pointer wrap, and level_o returns to 0.
REQ-029 Simultaneous: at level 8, assert wr_en_i and rd_en_i for 20 cycles -> level_o stays 8 and data order is preserved.
REQ-030 FWFT mode: write 0xA5 into an empty FIFO -> valid_o=1 and data_o=0xA5 two cycles later; write 0xB6 then pop -> data_o=0xB6 next cycle.
REQ-031 Flush and reset: at level 9 with overflow_o set, pulse clr_i together with wr_en_i -> level_o=0 and overflow_o=0; repeat with rst=0 -> all REQ-022 reset values.
